// File: rtl/fetch_pc_ctrl_if.sv
// Fetch request bus between the PC controller and the I-side.
//   if_valid_o  fetch request valid        (controller -> I-side)
//   F_PC_o      fetch request address      (controller -> I-side)
//   kill_o      transferred fetch is dead  (controller -> I-side)
//   if_ready_i  I-side accepts request     (I-side -> controller)
interface fetch_pc_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                if_valid_o;
    logic [PC_WIDTH-1:0] F_PC_o;
    logic                kill_o;
    logic                if_ready_i;

    modport master (
        output if_valid_o,
        output F_PC_o,
        output kill_o,
        input  if_ready_i
    );

    modport slave (
        input  if_valid_o,
        input  F_PC_o,
        input  kill_o,
        output if_ready_i
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner and fetch-request sequencer.
// Arbitrates execute redirect > mini-decode redirect > PC+4 into the next
// fetch PC, buffers one redirect while the fetch handshake is blocked and
// flags wrong-path transfers with kill_o.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   stall_i                 backend stall, suppresses requests
//   ex_redirect_i/_pc_i     execute-stage redirect and target
//   mini_redirect_i/_pc_i   mini-decode redirect and target
//   if_bus (master)         fetch request bus (valid/F_PC/kill/ready)
// Optional build macro FETCH_PERF_CNT_EN adds saturating redirect counters
//   ex_redir_cnt_o and mini_redir_cnt_o.
module fetch_pc_ctrl #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h8000_0000)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                stall_i,
    input  logic                ex_redirect_i,
    input  logic [PC_WIDTH-1:0] ex_redirect_pc_i,
    input  logic                mini_redirect_i,
    input  logic [PC_WIDTH-1:0] mini_redirect_pc_i,
    fetch_pc_ctrl_if.master     if_bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         ex_redir_cnt_o,
    output logic [31:0]         mini_redir_cnt_o
`endif
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                pend_vld_q, pend_vld_d;
    logic                pend_src_q, pend_src_d;   // 1 = execute, 0 = mini-decode
    logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic                if_valid_c;
    logic                xfer_c;
    logic [PC_WIDTH-1:0] ex_tgt_c;
    logic [PC_WIDTH-1:0] mini_tgt_c;

    // Handshake and word-aligned redirect targets
    always_comb begin
        ex_tgt_c   = ex_redirect_pc_i & ALIGN_MASK;
        mini_tgt_c = mini_redirect_pc_i & ALIGN_MASK;
        if_valid_c = (state_q != ST_BOOT) & ~stall_i;
        xfer_c     = if_valid_c & if_bus.if_ready_i;
    end

    assign if_bus.if_valid_o = if_valid_c;
    assign if_bus.F_PC_o     = pc_q;
    assign if_bus.kill_o     = xfer_c & (ex_redirect_i | mini_redirect_i | pend_vld_q);

    // Next-state, next-PC and redirect buffer
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_src_d = pend_src_q;
        pend_pc_d  = pend_pc_q;

        if (xfer_c) begin
            if (ex_redirect_i)                  pc_d = ex_tgt_c;
            else if (pend_vld_q && pend_src_q)  pc_d = pend_pc_q;
            else if (mini_redirect_i)           pc_d = mini_tgt_c;
            else if (pend_vld_q)                pc_d = pend_pc_q;
            else                                pc_d = pc_q + PC_WIDTH'(4);
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!xfer_c && (ex_redirect_i || mini_redirect_i)) begin
                    pend_vld_d = 1'b1;
                    pend_src_d = ex_redirect_i;
                    pend_pc_d  = ex_redirect_i ? ex_tgt_c : mini_tgt_c;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (xfer_c) begin
                    pend_vld_d = 1'b0;
                    pend_src_d = 1'b0;
                    pend_pc_d  = '0;
                    state_d    = ST_RUN;
                end else if (ex_redirect_i) begin
                    pend_src_d = 1'b1;
                    pend_pc_d  = ex_tgt_c;
                end else if (mini_redirect_i && !pend_src_q) begin
                    // A held execute redirect is never displaced by mini-decode
                    pend_pc_d  = mini_tgt_c;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_src_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_src_q <= pend_src_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ex_cnt_q, ex_cnt_d;
    logic [31:0] mini_cnt_q, mini_cnt_d;

    // Saturating counts of cycles each redirect input is asserted
    always_comb begin
        ex_cnt_d   = ex_cnt_q;
        mini_cnt_d = mini_cnt_q;
        if (ex_redirect_i && (ex_cnt_q != 32'hFFFF_FFFF))     ex_cnt_d   = ex_cnt_q + 32'd1;
        if (mini_redirect_i && (mini_cnt_q != 32'hFFFF_FFFF)) mini_cnt_d = mini_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_cnt_q   <= '0;
            mini_cnt_q <= '0;
        end else begin
            ex_cnt_q   <= ex_cnt_d;
            mini_cnt_q <= mini_cnt_d;
        end
    end

    assign ex_redir_cnt_o   = ex_cnt_q;
    assign mini_redir_cnt_o = mini_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: expected valid/PC/kill are queued as
// each cycle's stimulus is driven and popped against the sampled outputs.
module tb_fetch_pc_ctrl;

    localparam int unsigned PC_WIDTH = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stall;
    logic                ex_redir;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                mini_redir;
    logic [PC_WIDTH-1:0] mini_pc;

    fetch_pc_ctrl_if #(.PC_WIDTH(PC_WIDTH)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ex_cnt;
    logic [31:0] mini_cnt;
`endif

    fetch_pc_ctrl #(.PC_WIDTH(PC_WIDTH), .RESET_PC(32'h8000_0000)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .stall_i            (stall),
        .ex_redirect_i      (ex_redir),
        .ex_redirect_pc_i   (ex_pc),
        .mini_redirect_i    (mini_redir),
        .mini_redirect_pc_i (mini_pc),
        .if_bus             (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .ex_redir_cnt_o     (ex_cnt),
        .mini_redir_cnt_o   (mini_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic ev, input logic [31:0] epc, input logic ek);
        exp_t e;
        e.tag = {name, ".valid"}; e.val = 32'(ev);  sb_q.push_back(e);
        e.tag = {name, ".pc"};    e.val = epc;      sb_q.push_back(e);
        e.tag = {name, ".kill"};  e.val = 32'(ek);  sb_q.push_back(e);
    endtask

    task automatic pop_one(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got output 0x%08h expected nothing queued", obs);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic pop_outputs();
        pop_one(32'(bus.if_valid_o));
        pop_one(bus.F_PC_o);
        pop_one(32'(bus.kill_o));
    endtask

    // Drive one cycle's inputs (called at posedge+1), queue expectations,
    // sample at the falling edge, then advance to the next posedge+1.
    task automatic run_cycle(input string name,
                             input logic st, input logic rdy,
                             input logic ex, input logic [31:0] xpc,
                             input logic mi, input logic [31:0] mpc,
                             input logic ev, input logic [31:0] epc, input logic ek);
        stall          = st;
        bus.if_ready_i = rdy;
        ex_redir       = ex;
        ex_pc          = xpc;
        mini_redir     = mi;
        mini_pc        = mpc;
        push_exp(name, ev, epc, ek);
        @(negedge clk);
        pop_outputs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        ex_redir       = 1'b0;
        ex_pc          = '0;
        mini_redir     = 1'b0;
        mini_pc        = '0;
        bus.if_ready_i = 1'b1;

        #12;
        push_exp("rst", 1'b0, 32'h8000_0000, 1'b0);
        pop_outputs();

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //        name    st  rdy ex  ex_pc         mi  mini_pc       valid pc            kill
        // T1: boot then sequential fetch
        run_cycle("t1_boot", 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h8000_0000, 0);
        run_cycle("t1_c1",   0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0000, 0);
        run_cycle("t1_c2",   0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0004, 0);
        run_cycle("t1_c3",   0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0008, 0);
        // T2: live mini redirect with transfer
        run_cycle("t2_x",    0, 1, 0, 32'h0,        1, 32'h8000_0100, 1, 32'h8000_000C, 1);
        run_cycle("t2_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0100, 0);
        // T3: ex beats mini in the same cycle
        run_cycle("t3_x",    0, 1, 1, 32'h8000_0200, 1, 32'h8000_0300, 1, 32'h8000_0104, 1);
        run_cycle("t3_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0200, 0);
        // T4: ex buffered while not ready; later mini ignored
        run_cycle("t4_ex",   0, 0, 1, 32'h8000_0400, 0, 32'h0,        1, 32'h8000_0204, 0);
        run_cycle("t4_mi",   0, 0, 0, 32'h0,        1, 32'h8000_0500, 1, 32'h8000_0204, 0);
        run_cycle("t4_hold", 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0204, 0);
        run_cycle("t4_x",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0204, 1);
        run_cycle("t4_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0400, 0);
        // T5: redirect during stall is buffered
        run_cycle("t5_s1",   1, 1, 0, 32'h0,        1, 32'h8000_0044, 0, 32'h8000_0404, 0);
        run_cycle("t5_s2",   1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h8000_0404, 0);
        run_cycle("t5_s3",   1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h8000_0404, 0);
        run_cycle("t5_x",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0404, 1);
        run_cycle("t5_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0044, 0);
        // Misaligned target has its low bits cleared
        run_cycle("al_x",    0, 1, 1, 32'h8000_0603, 0, 32'h0,        1, 32'h8000_0048, 1);
        run_cycle("al_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0600, 0);
        // New mini overwrites a mini pend
        run_cycle("mo_1",    0, 0, 0, 32'h0,        1, 32'h8000_0800, 1, 32'h8000_0604, 0);
        run_cycle("mo_2",    0, 0, 0, 32'h0,        1, 32'h8000_0900, 1, 32'h8000_0604, 0);
        run_cycle("mo_x",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0604, 1);
        run_cycle("mo_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0900, 0);
        // PC+4 wraps at the top of the address space
        run_cycle("wr_x",    0, 1, 1, 32'hFFFF_FFFE, 0, 32'h0,        1, 32'h8000_0904, 1);
        run_cycle("wr_top",  0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 0);
        run_cycle("wr_zero", 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0);
        // Ex overwrites a mini pend; pended ex beats a live mini at transfer
        run_cycle("eo_mi",   0, 0, 0, 32'h0,        1, 32'h8000_0A00, 1, 32'h0000_0004, 0);
        run_cycle("eo_ex",   0, 0, 1, 32'h8000_0B00, 0, 32'h0,        1, 32'h0000_0004, 0);
        run_cycle("eo_x",    0, 1, 0, 32'h0,        1, 32'h8000_0C00, 1, 32'h0000_0004, 1);
        run_cycle("eo_n",    0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0B00, 0);
        // T6: reset while holding a pend
        run_cycle("t6_pend", 0, 0, 1, 32'h8000_0700, 0, 32'h0,        1, 32'h8000_0B04, 0);
        ex_redir       = 1'b0;
        bus.if_ready_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        push_exp("t6_rst", 1'b0, 32'h8000_0000, 1'b0);
        pop_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle("t6_boot", 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h8000_0000, 0);
        run_cycle("t6_c1",   0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0000, 0);
        run_cycle("t6_c2",   0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0004, 0);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
